// File: rtl/btb_pkg.sv
// Shared types, constants and index/tag helpers for the branch target buffer.
package btb_pkg;

  localparam int unsigned IDX_W_DEF = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RST   = WNT;
  localparam ctr_e CTR_ALLOC = WT;

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int unsigned idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // Tag: every PC bit above the index field.
  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// 2-bit saturating branch-history counter next-state.
module bht_sat_counter
  import btb_pkg::*;
(
  input  ctr_e cur,
  input  logic taken,
  output ctr_e nxt
);

  // Step toward taken or not-taken, holding at the extremes.
  always_comb begin
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit BHT: IF-stage lookup, EX-stage training and
// mispredict detection, plus branch/miss statistics.
module branch_target_buffer
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PCF,
  output logic             PredTakenF,
  output logic [31:0]      PredTargetF,
  input  logic             UpdateE,
  input  logic [31:0]      PCE,
  input  logic             BranchE,
  input  logic [31:0]      BranchTargetE,
  input  logic             PredTakenE,
  input  logic [31:0]      PredTargetE,
  output logic             MispredictE,
  output logic [31:0]      RecoverPCE,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] MissCount
);

  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];
  ctr_e             ctr_q    [DEPTH];

  logic [IDX_W-1:0] look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  ctr_e             ctr_nxt;

  assign look_idx = IDX_W'(btb_idx(PCF, IDX_W));
  assign look_tag = TAG_W'(btb_tag(PCF, IDX_W));
  assign upd_idx  = IDX_W'(btb_idx(PCE, IDX_W));
  assign upd_tag  = TAG_W'(btb_tag(PCE, IDX_W));

  // Fetch-side lookup; reads pre-edge contents, no bypass from EX training.
  always_comb begin
    look_hit    = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    PredTakenF  = look_hit && ctr_q[look_idx][1];
    PredTargetF = PredTakenF ? target_q[look_idx] : PCF + 32'd4;
  end

  // Resolution of the EX branch against what fetch predicted for it.
  always_comb begin
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    MispredictE = UpdateE && ((PredTakenE != BranchE) ||
                              (PredTakenE && BranchE && (PredTargetE != BranchTargetE)));
    RecoverPCE  = BranchE ? BranchTargetE : PCE + 32'd4;
  end

  bht_sat_counter u_ctr (
    .cur   (ctr_q[upd_idx]),
    .taken (BranchE),
    .nxt   (ctr_nxt)
  );

  // Valid bits and history counters; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[IDX_W'(i)] <= 1'b0;
        ctr_q[IDX_W'(i)]   <= CTR_RST;
      end
    end else if (UpdateE) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_nxt;
      end else if (BranchE) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= CTR_ALLOC;
      end
    end
  end

  // Tag and target payload; written on every taken update (tag is unchanged on a hit).
  always_ff @(posedge clk) begin
    if (!rst && UpdateE && BranchE) begin
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= BranchTargetE;
    end
  end

  // Performance counters, wrapping naturally at CNT_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else if (UpdateE) begin
      BranchCount <= BranchCount + CNT_W'(1);
      if (MispredictE) MissCount <= MissCount + CNT_W'(1);
    end
  end

endmodule
